serial_frame_rx: RTL

Serial frame receiver that sits directly upstream of the three PWM channels. It samples the external serial bus (`clock_data`, `data`, `latch`) in the system clock domain and assembles 36-bit frames. Each complete, valid frame is split into three 10-bit duty values, which are held stable between updates. It replaces direct use of external-clock registers and ensures the PWM stage only ever sees whole, checked frames.

---
 rtl/serial_frame_pkg.sv | 30 +++
 rtl/sync_edge.sv | 29 ++
 rtl/serial_frame_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared constants, FSM state type and header check for serial_frame_rx
package serial_frame_pkg;

   localparam int FRAME_BITS = 36;
   localparam int DUTY_W     = 10;
   localparam int HDR_W      = 6;
   localparam int DUTY1_LSB  = 6;
   localparam int DUTY2_LSB  = 16;
   localparam int DUTY3_LSB  = 26;
   localparam int CNT_W      = 6;

   localparam logic [CNT_W-1:0] CNT_FULL = 6'd36;
   localparam logic [CNT_W-1:0] CNT_OVFL = 6'd37;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OVFL  = 2'd2
   } rx_state_t;

   // Header is the low bits of the 12-bit sum of the three duty fields.
   function automatic logic [HDR_W-1:0] frame_sum(input logic [DUTY_W-1:0] a,
                                                  input logic [DUTY_W-1:0] b,
                                                  input logic [DUTY_W-1:0] c);
      logic [11:0] s;
      s = 12'(a) + 12'(b) + 12'(c);
      return s[HDR_W-1:0];
   endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-FF synchronizer with a third register for rising-edge detect
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync,
   output logic rise
);

   logic meta;
   logic sync_q;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         prev   <= 1'b0;
      end else begin
         meta   <= async_in;
         sync_q <= meta;
         prev   <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev;

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - serial bus frame receiver feeding the PWM duty registers
// Optional header check against the duty sum when SERIAL_FRAME_CHECK_EN is defined.
module serial_frame_rx #(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clock_data,
   input  logic       data,
   input  logic       latch,
   output logic [9:0] duty1,
   output logic [9:0] duty2,
   output logic [9:0] duty3,
   output logic       frame_valid,
   output logic       frame_error,
   output logic       busy,
   output logic [7:0] err_count
);

   import serial_frame_pkg::*;

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   logic                  cd_rise;
   logic                  latch_rise;
   logic                  unused_cd_sync;
   logic                  unused_latch_sync;
   logic                  data_meta;
   logic                  data_sync;
   rx_state_t             state;
   rx_state_t             next_state;
   logic [CNT_W-1:0]      bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [TMR_W-1:0]      idle_tmr;
   logic                  take_bit;
   logic                  timeout;
   logic                  accept;
   logic                  reject;
   logic                  frame_ok;
   logic [DUTY_W-1:0]     f_duty1;
   logic [DUTY_W-1:0]     f_duty2;
   logic [DUTY_W-1:0]     f_duty3;

   sync_edge u_cd_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (clock_data),
      .sync     (unused_cd_sync),
      .rise     (cd_rise)
   );

   sync_edge u_latch_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (latch),
      .sync     (unused_latch_sync),
      .rise     (latch_rise)
   );

   // Same two-stage depth as clock_data, so data_sync lines up with cd_rise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_meta <= 1'b0;
         data_sync <= 1'b0;
      end else begin
         data_meta <= data;
         data_sync <= data_meta;
      end
   end

   assign f_duty1 = shreg[DUTY1_LSB +: DUTY_W];
   assign f_duty2 = shreg[DUTY2_LSB +: DUTY_W];
   assign f_duty3 = shreg[DUTY3_LSB +: DUTY_W];

`ifdef SERIAL_FRAME_CHECK_EN
   assign frame_ok = (bit_cnt == CNT_FULL) &&
                     (shreg[HDR_W-1:0] == frame_sum(f_duty1, f_duty2, f_duty3));
`else
   logic [HDR_W-1:0] unused_hdr;
   assign unused_hdr = shreg[HDR_W-1:0];
   assign frame_ok   = (bit_cnt == CNT_FULL);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // A latch rise wins over a same-cycle bit, which is then dropped.
   always_comb begin
      next_state = state;
      take_bit   = 1'b0;
      timeout    = 1'b0;
      accept     = 1'b0;
      reject     = 1'b0;
      if (latch_rise) begin
         accept     = frame_ok;
         reject     = ~frame_ok;
         next_state = IDLE;
      end else if (cd_rise) begin
         take_bit = 1'b1;
         unique case (state)
            IDLE:    next_state = SHIFT;
            SHIFT:   if (bit_cnt == CNT_FULL) next_state = OVFL;
            default: next_state = state;
         endcase
      end else if (state != IDLE && idle_tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
         timeout    = 1'b1;
         next_state = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         idle_tmr <= '0;
      end else if (latch_rise || timeout) begin
         bit_cnt  <= '0;
         shreg    <= '0;
         idle_tmr <= '0;
      end else if (take_bit) begin
         if (bit_cnt < CNT_FULL) shreg[bit_cnt] <= data_sync;
         if (bit_cnt < CNT_OVFL) bit_cnt <= bit_cnt + 6'd1;
         idle_tmr <= '0;
      end else if (state != IDLE) begin
         idle_tmr <= idle_tmr + TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty1       <= '0;
         duty2       <= '0;
         duty3       <= '0;
         frame_valid <= 1'b0;
         frame_error <= 1'b0;
         err_count   <= '0;
      end else begin
         frame_valid <= accept;
         frame_error <= reject;
         if (accept) begin
            duty1 <= f_duty1;
            duty2 <= f_duty2;
            duty3 <= f_duty3;
         end
         if (reject && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
   end

   assign busy = (bit_cnt != '0);

endmodule
